inst_queue: RTL and testbench

Two-wide instruction queue between the fetch stage and decode. It accepts up to FETCH_WIDTH instruction/PC pairs per cycle from fetch and presents up to two in-order entries per cycle to decode. It decouples decode backpressure from fetch through a registered stall back to fetch. It flushes on redirect, and drops a wrong-path bundle that fetch was holding under stall during the redirect.

---
 rtl/inst_queue.sv | 141 ++++++++++++++
 tb/tb_inst_queue.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - two-wide fetch-to-decode instruction queue; optional stats via INST_QUEUE_STATS_EN
module inst_queue #(
  parameter int XLEN        = 32,
  parameter int FETCH_WIDTH = 2,
  parameter int DEPTH       = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [FETCH_WIDTH-1:0]      if_valid,
  input  logic [FETCH_WIDTH*XLEN-1:0] if_pc,
  input  logic [FETCH_WIDTH*XLEN-1:0] if_instr,
  output logic                        fetch_stall,
  input  logic                        redirect_en,
  output logic [1:0]                  dq_valid,
  output logic [2*XLEN-1:0]           dq_pc,
  output logic [2*XLEN-1:0]           dq_instr,
  input  logic [1:0]                  dec_ready
`ifdef INST_QUEUE_STATS_EN
  ,
  output logic [31:0]                 perf_full_cycles,
  output logic [31:0]                 perf_flushes
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, SQUASH} sq_state_t;

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [AW:0]     count;
  sq_state_t       sq_state;
  sq_state_t       sq_state_next;
  logic            squash_pending;
  logic            accept;
  logic [1:0]      enq_n;
  logic [1:0]      deq_n;
  logic [AW-1:0]   head_p1;
  logic [AW-1:0]   tail_p1;

  assign squash_pending = (sq_state == SQUASH);
  assign fetch_stall    = (count > (AW+1)'(DEPTH - 2));
  assign accept         = (|if_valid) && !fetch_stall && !redirect_en && !squash_pending;
  assign enq_n          = {1'b0, if_valid[0] & accept} + {1'b0, if_valid[1] & accept};
  assign deq_n          = {1'b0, dq_valid[0] & dec_ready[0]}
                        + {1'b0, dq_valid[1] & dec_ready[1] & dec_ready[0]};
  assign head_p1        = head + AW'(1);
  assign tail_p1        = tail + AW'(1);

  // Squash tracker: remember that fetch is still holding a wrong-path bundle after a flush
  always_ff @(posedge clk) begin
    if (reset) begin
      sq_state <= IDLE;
    end else begin
      sq_state <= sq_state_next;
    end
  end

  // Arm on a redirect that catches a held bundle; disarm when that bundle is offered and dropped
  always_comb begin
    sq_state_next = sq_state;
    case (sq_state)
      IDLE: begin
        if (redirect_en && fetch_stall && (|if_valid)) begin
          sq_state_next = SQUASH;
        end
      end
      SQUASH: begin
        if (!redirect_en && (|if_valid) && !fetch_stall) begin
          sq_state_next = IDLE;
        end
      end
      default: sq_state_next = IDLE;
    endcase
  end

  // Pointer and occupancy bookkeeping; a redirect empties the queue outright
  always_ff @(posedge clk) begin
    if (reset || redirect_en) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(deq_n);
      tail  <= tail + AW'(enq_n);
      count <= count + (AW+1)'(enq_n) - (AW+1)'(deq_n);
    end
  end

  // Storage write: valid lanes are packed into consecutive slots starting at tail
  always_ff @(posedge clk) begin
    if (accept) begin
      if (if_valid[0]) begin
        pc_mem[tail]    <= if_pc[XLEN-1:0];
        instr_mem[tail] <= if_instr[XLEN-1:0];
        if (if_valid[1]) begin
          pc_mem[tail_p1]    <= if_pc[2*XLEN-1:XLEN];
          instr_mem[tail_p1] <= if_instr[2*XLEN-1:XLEN];
        end
      end else begin
        pc_mem[tail]    <= if_pc[2*XLEN-1:XLEN];
        instr_mem[tail] <= if_instr[2*XLEN-1:XLEN];
      end
    end
  end

  // Decode view: oldest two entries, zeroed when not valid
  always_comb begin
    dq_valid = {count >= (AW+1)'(2), count >= (AW+1)'(1)};
    dq_pc    = '0;
    dq_instr = '0;
    if (dq_valid[0]) begin
      dq_pc[XLEN-1:0]    = pc_mem[head];
      dq_instr[XLEN-1:0] = instr_mem[head];
    end
    if (dq_valid[1]) begin
      dq_pc[2*XLEN-1:XLEN]    = pc_mem[head_p1];
      dq_instr[2*XLEN-1:XLEN] = instr_mem[head_p1];
    end
  end

`ifdef INST_QUEUE_STATS_EN
  // Saturating event counters for stall cycles and flushes
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_full_cycles <= '0;
      perf_flushes     <= '0;
    end else begin
      if (fetch_stall && (perf_full_cycles != '1)) begin
        perf_full_cycles <= perf_full_cycles + 32'd1;
      end
      if (redirect_en && (perf_flushes != '1)) begin
        perf_flushes <= perf_flushes + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - directed bench with queue-based reference model for inst_queue
module tb_inst_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      if_valid;
  logic [63:0]     if_pc;
  logic [63:0]     if_instr;
  logic            fetch_stall;
  logic            redirect_en;
  logic [1:0]      dq_valid;
  logic [63:0]     dq_pc;
  logic [63:0]     dq_instr;
  logic [1:0]      dec_ready;
`ifdef INST_QUEUE_STATS_EN
  logic [31:0]     perf_full_cycles;
  logic [31:0]     perf_flushes;
`endif

  int total = 0;
  int bad   = 0;
  bit armed = 0;

  logic [31:0] m_pc[$];
  logic [31:0] m_in[$];
  bit          m_sq;
  logic [31:0] m_full;
  logic [31:0] m_flush;

  inst_queue #(.XLEN(XLEN), .FETCH_WIDTH(2), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .if_valid(if_valid),
    .if_pc(if_pc),
    .if_instr(if_instr),
    .fetch_stall(fetch_stall),
    .redirect_en(redirect_en),
    .dq_valid(dq_valid),
    .dq_pc(dq_pc),
    .dq_instr(dq_instr),
    .dec_ready(dec_ready)
`ifdef INST_QUEUE_STATS_EN
    ,
    .perf_full_cycles(perf_full_cycles),
    .perf_flushes(perf_flushes)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc * 32'h0000_9E37 + 32'h0000_0013;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: apply one clock edge's worth of queue semantics
  task automatic model_step();
    int  sz;
    bit  st;
    int  d;
    sz = m_pc.size();
    st = (sz > DEPTH - 2);
    if (reset) begin
      m_pc.delete();
      m_in.delete();
      m_sq    = 0;
      m_full  = 0;
      m_flush = 0;
    end else begin
      if (st && m_full != 32'hFFFF_FFFF) m_full = m_full + 1;
      if (redirect_en && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
      if (redirect_en) begin
        if (st && (if_valid != 2'b00)) m_sq = 1;
        m_pc.delete();
        m_in.delete();
      end else begin
        d = 0;
        if (sz >= 1 && dec_ready[0]) d = 1;
        if (sz >= 2 && dec_ready[0] && dec_ready[1]) d = 2;
        for (int i = 0; i < d; i++) begin
          void'(m_pc.pop_front());
          void'(m_in.pop_front());
        end
        if ((if_valid != 2'b00) && !st) begin
          if (m_sq) begin
            m_sq = 0;
          end else begin
            if (if_valid[0]) begin
              m_pc.push_back(if_pc[31:0]);
              m_in.push_back(if_instr[31:0]);
            end
            if (if_valid[1]) begin
              m_pc.push_back(if_pc[63:32]);
              m_in.push_back(if_instr[63:32]);
            end
          end
        end
      end
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (armed) begin
      int sz;
      logic [63:0] epc;
      logic [63:0] ein;
      sz  = m_pc.size();
      epc = '0;
      ein = '0;
      if (sz >= 1) begin epc[31:0]  = m_pc[0]; ein[31:0]  = m_in[0]; end
      if (sz >= 2) begin epc[63:32] = m_pc[1]; ein[63:32] = m_in[1]; end
      chk("cyc_fetch_stall", {63'd0, fetch_stall}, {63'd0, sz > DEPTH - 2});
      chk("cyc_dq_valid", {62'd0, dq_valid}, {62'd0, sz >= 2, sz >= 1});
      chk("cyc_dq_pc", dq_pc, epc);
      chk("cyc_dq_instr", dq_instr, ein);
`ifdef INST_QUEUE_STATS_EN
      chk("cyc_perf_full", {32'd0, perf_full_cycles}, {32'd0, m_full});
      chk("cyc_perf_flush", {32'd0, perf_flushes}, {32'd0, m_flush});
`endif
    end
  end

  task automatic cyc(input logic rst, input logic [1:0] v, input logic [31:0] p0,
                     input logic [31:0] p1, input logic [1:0] r, input logic red);
    reset       = rst;
    if_valid    = v;
    if_pc       = {p1, p0};
    if_instr    = {instr_of(p1), instr_of(p0)};
    dec_ready   = r;
    redirect_en = red;
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    cyc(1, 2'b00, 0, 0, 2'b00, 0);
    cyc(1, 2'b11, 32'h10, 32'h14, 2'b11, 1);
    armed = 1;
    chk("rst_valid", {62'd0, dq_valid}, 64'd0);
    chk("rst_stall", {63'd0, fetch_stall}, 64'd0);
    chk("rst_pc", dq_pc, 64'd0);

    // Fill four full bundles with decode stalled
    for (int k = 0; k < 4; k++) begin
      cyc(0, 2'b11, 32'(8*k), 32'(8*k + 4), 2'b00, 0);
      if (k == 2) chk("fill_no_stall_at6", {63'd0, fetch_stall}, 64'd0);
    end
    chk("fill_stall", {63'd0, fetch_stall}, 64'd1);
    chk("fill_pc", dq_pc, {32'h4, 32'h0});
    chk("fill_model_cnt", 64'(m_pc.size()), 64'd8);

    // Drain two per cycle
    cyc(0, 2'b00, 0, 0, 2'b11, 0);
    chk("drain_stall_drop", {63'd0, fetch_stall}, 64'd0);
    chk("drain_pc1", dq_pc, {32'hC, 32'h8});
    for (int k = 0; k < 3; k++) cyc(0, 2'b00, 0, 0, 2'b11, 0);
    chk("drain_empty", {62'd0, dq_valid}, 64'd0);

    // Partial lanes, one-per-cycle decode
    cyc(0, 2'b10, 32'h100, 32'h104, 2'b01, 0);
    chk("part_lane1", dq_pc, {32'h0, 32'h104});
    cyc(0, 2'b01, 32'h108, 32'h10C, 2'b01, 0);
    chk("part_lane0", dq_pc, {32'h0, 32'h108});
    cyc(0, 2'b00, 0, 0, 2'b11, 0);

    // Concurrent enqueue/dequeue at six entries, then at seven (stalled)
    for (int k = 0; k < 3; k++) cyc(0, 2'b11, 32'(32'h200 + 8*k), 32'(32'h204 + 8*k), 2'b00, 0);
    cyc(0, 2'b11, 32'h230, 32'h234, 2'b11, 0);
    chk("conc_pc", dq_pc, {32'h20C, 32'h208});
    chk("conc_cnt", 64'(m_pc.size()), 64'd6);
    cyc(0, 2'b01, 32'h238, 32'h23C, 2'b00, 0);
    chk("conc7_stall", {63'd0, fetch_stall}, 64'd1);
    cyc(0, 2'b11, 32'h240, 32'h244, 2'b11, 0);
    chk("conc7_cnt", 64'(m_pc.size()), 64'd5);

    // Redirect while a bundle is held under stall
    cyc(0, 2'b11, 32'h248, 32'h24C, 2'b00, 0);
    cyc(0, 2'b11, 32'h300, 32'h304, 2'b00, 0);
    cyc(0, 2'b11, 32'h300, 32'h304, 2'b00, 1);
    chk("redir_empty", {62'd0, dq_valid}, 64'd0);
    chk("redir_stall", {63'd0, fetch_stall}, 64'd0);
    cyc(0, 2'b11, 32'h300, 32'h304, 2'b00, 0);
    chk("squash_drop", {62'd0, dq_valid}, 64'd0);
    cyc(0, 2'b11, 32'h400, 32'h404, 2'b00, 0);
    chk("post_squash_pc", dq_pc, {32'h404, 32'h400});

    // Redirect without stall must not squash the next bundle
    cyc(0, 2'b11, 32'h410, 32'h414, 2'b01, 1);
    cyc(0, 2'b01, 32'h418, 32'h41C, 2'b00, 0);
    chk("redir_nostall_pc", dq_pc, {32'h0, 32'h418});

    // Arm squash, then reset must clear it
    cyc(0, 2'b11, 32'h500, 32'h504, 2'b00, 0);
    cyc(0, 2'b11, 32'h508, 32'h50C, 2'b00, 0);
    cyc(0, 2'b11, 32'h510, 32'h514, 2'b00, 0);
    cyc(0, 2'b11, 32'h510, 32'h514, 2'b00, 1);
    cyc(1, 2'b11, 32'h510, 32'h514, 2'b00, 1);
    chk("rst_sq_valid", {62'd0, dq_valid}, 64'd0);
`ifdef INST_QUEUE_STATS_EN
    chk("rst_sq_perf", {perf_full_cycles, perf_flushes}, 64'd0);
`endif
    cyc(0, 2'b11, 32'h600, 32'h604, 2'b00, 0);
    chk("rst_sq_accept", dq_pc, {32'h604, 32'h600});

    // Reset at five entries
    cyc(0, 2'b11, 32'h608, 32'h60C, 2'b00, 0);
    cyc(0, 2'b01, 32'h610, 32'h614, 2'b00, 0);
    chk("mid_cnt5", 64'(m_pc.size()), 64'd5);
    cyc(1, 2'b11, 32'h618, 32'h61C, 2'b11, 0);
    chk("mid_rst_valid", {62'd0, dq_valid}, 64'd0);
    chk("mid_rst_pc", dq_pc, 64'd0);
    chk("mid_rst_instr", dq_instr, 64'd0);
    cyc(0, 2'b00, 0, 0, 2'b00, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
